// File: rtl/qsim_pkg.sv
// Shared types and fixed-point constants for the Kronecker state sequencer.
// Complex values are signed with N-2 fraction bits, i.e. range [-2.0, 2.0).
package qsim_pkg;

    localparam int CPLX_W = 16;

    function automatic int frac_bits(input int n);
        return n - 2;
    endfunction

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MULT = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic signed [CPLX_W-1:0] Q_ONE = CPLX_W'(1 << (CPLX_W - 2));

endpackage

// File: rtl/complex_mult.sv
// Combinational saturating complex multiplier in the qsim fixed-point format.
// ovr flags that either component had to be clipped to the N-bit range.
module complex_mult
    import qsim_pkg::*;
#(
    parameter int N = 16
) (
    input  logic signed [N-1:0] a_re,
    input  logic signed [N-1:0] a_im,
    input  logic signed [N-1:0] b_re,
    input  logic signed [N-1:0] b_im,
    output logic signed [N-1:0] p_re,
    output logic signed [N-1:0] p_im,
    output logic                ovr
);
    localparam int W = 2 * N + 1;
    localparam int F = frac_bits(N);
    localparam logic signed [W-1:0] MAX_V = {{(N + 2){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {{(N + 2){1'b1}}, {(N - 1){1'b0}}};

    logic signed [W-1:0] ar, ai, br, bi;
    logic signed [W-1:0] sum_re, sum_im, sh_re, sh_im;

    function automatic logic signed [N-1:0] sat(input logic signed [W-1:0] v);
        if (v > MAX_V)      return MAX_V[N-1:0];
        else if (v < MIN_V) return MIN_V[N-1:0];
        else                return v[N-1:0];
    endfunction

    assign ar = W'(a_re);
    assign ai = W'(a_im);
    assign br = W'(b_re);
    assign bi = W'(b_im);

    // Full-precision sums fit in 2N+1 bits before rescaling.
    assign sum_re = ar * br - ai * bi;
    assign sum_im = ar * bi + ai * br;
    assign sh_re  = sum_re >>> F;
    assign sh_im  = sum_im >>> F;

    assign p_re = sat(sh_re);
    assign p_im = sat(sh_im);
    assign ovr  = (sh_re > MAX_V) || (sh_re < MIN_V) || (sh_im > MAX_V) || (sh_im < MIN_V);

endmodule

// File: rtl/kron_state_sequencer.sv
// Streams the 2^NQ amplitudes of the tensor product of NQ loaded qubits.
// Define KRON_OVR_EN to get a sticky multiplier-overflow flag; otherwise ovr_flag is 0.
module kron_state_sequencer
    import qsim_pkg::*;
#(
    parameter int N  = 16,
    parameter int NQ = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                q_valid,
    output logic                q_ready,
    input  logic signed [N-1:0] q_data [0:3],
    input  logic                abort,
    output logic                o_valid,
    input  logic                o_ready,
    output logic signed [N-1:0] o_re,
    output logic signed [N-1:0] o_im,
    output logic [NQ-1:0]       o_idx,
    output logic                o_last,
    output logic                busy,
    output logic                ovr_flag
);
    localparam int QCW = $clog2(NQ);
    localparam logic [NQ-1:0]  K_LAST    = '1;
    localparam logic [QCW-1:0] SLOT_LAST = QCW'(NQ - 1);

    state_t              state;
    logic [QCW-1:0]      q_cnt, step, bit_pos;
    logic [NQ-1:0]       k, k_inc, k_shift;
    logic signed [N-1:0] slot [NQ][4];
    logic signed [N-1:0] acc_re, acc_im, amp_re, amp_im, prod_re, prod_im, first_re, first_im;
    logic                q_fire, mult_ovr, k_next_msb;

    assign q_ready = (state == IDLE) || (state == LOAD);
    assign q_fire  = q_valid && q_ready;
    assign k_inc   = k + 1'b1;

    // Qubit s contributes index bit NQ-1-s, so qubit 0 lands on the MSB.
    assign bit_pos = SLOT_LAST - step;
    assign k_shift = k >> bit_pos;
    assign amp_re  = k_shift[0] ? slot[step][2] : slot[step][0];
    assign amp_im  = k_shift[0] ? slot[step][3] : slot[step][1];

    assign k_next_msb = (state == OUT) ? k_inc[NQ-1] : 1'b0;
    assign first_re   = k_next_msb ? slot[0][2] : slot[0][0];
    assign first_im   = k_next_msb ? slot[0][3] : slot[0][1];

    complex_mult #(.N(N)) u_mult (
        .a_re (acc_re),
        .a_im (acc_im),
        .b_re (amp_re),
        .b_im (amp_im),
        .p_re (prod_re),
        .p_im (prod_im),
        .ovr  (mult_ovr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NQ; i++)
                for (int j = 0; j < 4; j++)
                    slot[i][j] <= '0;
        end else if (q_fire && !abort) begin
            for (int j = 0; j < 4; j++)
                slot[q_cnt][j] <= q_data[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            q_cnt   <= '0;
            k       <= '0;
            step    <= '0;
            acc_re  <= '0;
            acc_im  <= '0;
            o_valid <= 1'b0;
            o_re    <= '0;
            o_im    <= '0;
            o_idx   <= '0;
            o_last  <= 1'b0;
            busy    <= 1'b0;
        end else if (abort) begin
            state   <= IDLE;
            q_cnt   <= '0;
            k       <= '0;
            step    <= '0;
            o_valid <= 1'b0;
            o_re    <= '0;
            o_im    <= '0;
            o_idx   <= '0;
            o_last  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (q_fire) begin
                        busy <= 1'b1;
                        if (q_cnt == SLOT_LAST) begin
                            // slot 0 is already loaded since NQ >= 2
                            state  <= MULT;
                            q_cnt  <= '0;
                            k      <= '0;
                            step   <= QCW'(1);
                            acc_re <= slot[0][0];
                            acc_im <= slot[0][1];
                        end else begin
                            state <= LOAD;
                            q_cnt <= q_cnt + 1'b1;
                        end
                    end
                end
                MULT: begin
                    acc_re <= prod_re;
                    acc_im <= prod_im;
                    step   <= step + 1'b1;
                    if (step == SLOT_LAST) begin
                        state   <= OUT;
                        o_valid <= 1'b1;
                        o_re    <= prod_re;
                        o_im    <= prod_im;
                        o_idx   <= k;
                        o_last  <= (k == K_LAST);
                    end
                end
                OUT: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        o_re    <= '0;
                        o_im    <= '0;
                        o_idx   <= '0;
                        o_last  <= 1'b0;
                        if (k == K_LAST) begin
                            state <= IDLE;
                            q_cnt <= '0;
                            k     <= '0;
                            busy  <= 1'b0;
                        end else begin
                            state  <= MULT;
                            k      <= k_inc;
                            step   <= QCW'(1);
                            acc_re <= first_re;
                            acc_im <= first_im;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KRON_OVR_EN
    logic ovr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovr_reg <= 1'b0;
        else if (!abort && q_fire && state == IDLE)
            ovr_reg <= 1'b0;
        else if (!abort && state == MULT && mult_ovr)
            ovr_reg <= 1'b1;
    end

    assign ovr_flag = ovr_reg;
`else
    assign ovr_flag = 1'b0;
`endif

endmodule

// File: tb/tb_kron_state_sequencer.sv
// Directed bench for kron_state_sequencer: one NQ=4 and one NQ=2 instance.
module tb_kron_state_sequencer;
    import qsim_pkg::*;

    localparam int N   = 16;
    localparam int ONE = int'(Q_ONE);
`ifdef KRON_OVR_EN
    localparam int OVR_EXP = 1;
`else
    localparam int OVR_EXP = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic                q_valid4, q_ready4, abort4, o_valid4, o_ready4, o_last4, busy4, ovr4;
    logic signed [N-1:0] q_data4 [0:3];
    logic signed [N-1:0] o_re4, o_im4;
    logic [3:0]          o_idx4;

    logic                q_valid2, q_ready2, abort2, o_valid2, o_ready2, o_last2, busy2, ovr2;
    logic signed [N-1:0] q_data2 [0:3];
    logic signed [N-1:0] o_re2, o_im2;
    logic [1:0]          o_idx2;

    int n_checks = 0;
    int n_fail   = 0;

    kron_state_sequencer #(.N(N), .NQ(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .q_valid(q_valid4), .q_ready(q_ready4), .q_data(q_data4),
        .abort(abort4), .o_valid(o_valid4), .o_ready(o_ready4), .o_re(o_re4), .o_im(o_im4),
        .o_idx(o_idx4), .o_last(o_last4), .busy(busy4), .ovr_flag(ovr4)
    );

    kron_state_sequencer #(.N(N), .NQ(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .q_valid(q_valid2), .q_ready(q_ready2), .q_data(q_data2),
        .abort(abort2), .o_valid(o_valid2), .o_ready(o_ready2), .o_re(o_re2), .o_im(o_im2),
        .o_idx(o_idx2), .o_last(o_last2), .busy(busy2), .ovr_flag(ovr2)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input bit d2, input int re0, input int im0, input int re1, input int im1);
        if (d2) begin
            q_valid2 = 1'b1;
            q_data2[0] = N'(re0); q_data2[1] = N'(im0); q_data2[2] = N'(re1); q_data2[3] = N'(im1);
            chk("q_ready2", q_ready2, 1);
            tick;
            q_valid2 = 1'b0;
        end else begin
            q_valid4 = 1'b1;
            q_data4[0] = N'(re0); q_data4[1] = N'(im0); q_data4[2] = N'(re1); q_data4[3] = N'(im1);
            chk("q_ready4", q_ready4, 1);
            tick;
            q_valid4 = 1'b0;
        end
    endtask

    // Waits (bounded) for o_valid, checks the amplitude, then handshakes it.
    task automatic take(input bit d2, input int idx, input int re, input int im, input int lat);
        int w = 0;
        while (!(d2 ? o_valid2 : o_valid4) && w < 40) begin
            tick;
            w++;
        end
        $display("amp dut%0d idx=%0d re=%0d im=%0d wait=%0d", d2 ? 2 : 4,
                 d2 ? o_idx2 : o_idx4, d2 ? o_re2 : o_re4, d2 ? o_im2 : o_im4, w);
        chk($sformatf("o_valid[%0d]", idx), d2 ? o_valid2 : o_valid4, 1);
        if (lat >= 0) chk($sformatf("latency[%0d]", idx), w, lat);
        chk($sformatf("o_idx[%0d]", idx), d2 ? o_idx2 : o_idx4, idx);
        chk($sformatf("o_re[%0d]", idx), d2 ? o_re2 : o_re4, re);
        chk($sformatf("o_im[%0d]", idx), d2 ? o_im2 : o_im4, im);
        chk($sformatf("o_last[%0d]", idx), d2 ? o_last2 : o_last4, int'(idx == (d2 ? 3 : 15)));
        tick;
    endtask

    initial begin
        rst_n = 1'b0;
        q_valid4 = 1'b0; abort4 = 1'b0; o_ready4 = 1'b1;
        q_valid2 = 1'b0; abort2 = 1'b0; o_ready2 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            q_data4[j] = '0;
            q_data2[j] = '0;
        end
        tick;
        tick;

        // Reset state
        chk("rst_busy", busy4, 0);
        chk("rst_q_ready", q_ready4, 1);
        chk("rst_o_valid", o_valid4, 0);
        chk("rst_o_re", o_re4, 0);
        chk("rst_o_idx", o_idx4, 0);
        chk("rst_o_last", o_last4, 0);
        chk("rst_ovr", ovr4, 0);
        chk("rst_busy2", busy2, 0);
        rst_n = 1'b1;
        tick;

        // NQ=2: |0> (x) i|1> gives i at index 1; one MULT cycle per amplitude
        push(1, ONE, 0, 0, 0);
        chk("busy2_load", busy2, 1);
        push(1, 0, 0, 0, ONE);
        chk("q_ready2_mult", q_ready2, 0);
        take(1, 0, 0, 0, 1);
        take(1, 1, 0, ONE, 1);
        take(1, 2, 0, 0, 1);
        take(1, 3, 0, 0, 1);
        chk("busy2_done", busy2, 0);
        chk("q_ready2_done", q_ready2, 1);

        // NQ=2: (-2.0)*(-2.0) saturates to the positive limit
        push(1, -32768, 0, 0, 0);
        push(1, -32768, 0, 0, 0);
        take(1, 0, 32767, 0, 1);
        take(1, 1, 0, 0, 1);
        take(1, 2, 0, 0, 1);
        take(1, 3, 0, 0, 1);
        chk("ovr2_after_sat", ovr2, OVR_EXP);
        abort2 = 1'b1;
        tick;
        abort2 = 1'b0;
        chk("ovr2_kept_by_abort", ovr2, OVR_EXP);
        push(1, ONE, 0, 0, 0);
        chk("ovr2_cleared_first_accept", ovr2, 0);
        abort2 = 1'b1;
        tick;
        abort2 = 1'b0;
        chk("busy2_after_abort", busy2, 0);

        // NQ=4: all qubits |0>
        for (int s = 0; s < 4; s++) push(0, ONE, 0, 0, 0);
        for (int i = 0; i < 16; i++) take(0, i, (i == 0) ? ONE : 0, 0, 3);
        chk("ovr4_basis", ovr4, 0);
        chk("busy4_done", busy4, 0);

        // NQ=4: uniform halves, with a 5-cycle stall at index 3
        for (int s = 0; s < 4; s++) push(0, ONE / 2, 0, ONE / 2, 0);
        for (int i = 0; i < 3; i++) take(0, i, ONE / 16, 0, 3);
        o_ready4 = 1'b0;
        begin
            int w = 0;
            while (!o_valid4 && w < 40) begin
                tick;
                w++;
            end
        end
        for (int c = 0; c < 5; c++) begin
            $display("stall cycle %0d idx=%0d re=%0d im=%0d valid=%0d", c, o_idx4, o_re4, o_im4, o_valid4);
            chk("stall_valid", o_valid4, 1);
            chk("stall_idx", o_idx4, 3);
            chk("stall_re", o_re4, ONE / 16);
            chk("stall_im", o_im4, 0);
            tick;
        end
        o_ready4 = 1'b1;
        take(0, 3, ONE / 16, 0, -1);
        for (int i = 4; i < 16; i++) take(0, i, ONE / 16, 0, 3);

        // Abort during MULT at k=6, then reset during LOAD
        for (int s = 0; s < 4; s++) push(0, ONE / 2, 0, ONE / 2, 0);
        for (int i = 0; i < 6; i++) take(0, i, ONE / 16, 0, 3);
        chk("pre_abort_busy", busy4, 1);
        abort4 = 1'b1;
        tick;
        abort4 = 1'b0;
        chk("abort_busy", busy4, 0);
        chk("abort_q_ready", q_ready4, 1);
        chk("abort_o_valid", o_valid4, 0);
        for (int c = 0; c < 6; c++) begin
            tick;
            chk("abort_no_valid", o_valid4, 0);
        end
        push(0, ONE, 0, 0, 0);
        push(0, ONE, 0, 0, 0);
        chk("load_busy", busy4, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy4, 0);
        chk("rst_mid_o_valid", o_valid4, 0);
        chk("rst_mid_o_re", o_re4, 0);
        chk("rst_mid_o_idx", o_idx4, 0);
        chk("rst_mid_q_ready", q_ready4, 1);
        chk("rst_mid_ovr", ovr4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        for (int s = 0; s < 4; s++) push(0, ONE, 0, 0, 0);
        take(0, 0, ONE, 0, 3);
        take(0, 1, 0, 0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kron_state_sequencer.md
KRON_STATE_SEQUENCER -- requirements
Module: kron_state_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the signed fixed-point width of each real or imaginary component.
REQ-002 The block SHALL have parameter NQ, default 4, giving the number of qubits; legal range is 2..8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 q_valid  input  1  a qubit vector is offered on q_data.
REQ-006 q_ready  output  1  the block accepts a qubit vector this cycle.
REQ-007 q_data  input  [N-1:0] x4 (unpacked [0:3])  re0, im0, re1, im1 of one qubit.
REQ-008 abort  input  1  synchronous return to IDLE.
REQ-009 o_valid  output  1  an amplitude is presented.
REQ-010 o_ready  input  1  downstream accepts the amplitude.
REQ-011 o_re, o_im  output  N each  amplitude value.
REQ-012 o_idx  output  NQ  basis-state index of the amplitude.
REQ-013 o_last  output  1  high with o_valid when o_idx equals 2^NQ-1.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 ovr_flag  output  1  sticky overflow from the multiplier.

Function
REQ-016 States SHALL be IDLE, LOAD, MULT and OUT.
REQ-017 q_ready SHALL be high exactly in IDLE and LOAD.
- A q_valid&&q_ready edge stores q_data into qubit slot q_cnt and increments q_cnt.
- The first accept moves IDLE to LOAD and clears ovr_flag.
REQ-018 On the accept that fills slot NQ-1, the block SHALL enter MULT with k=0, step=1 and acc={qubit[0] amplitude selected by bit NQ-1 of k}.
REQ-019 Each MULT cycle SHALL perform acc <= acc x qubit[step] amplitude selected by bit (NQ-1-step) of k, using one shared complex multiplier.
- Qubit 0 maps to the MSB of the index.
REQ-020 After NQ-1 MULT cycles the block SHALL enter OUT, so o_valid rises NQ-1 cycles after entering MULT.
REQ-021 In OUT, o_valid SHALL be high and o_re, o_im and o_idx SHALL hold stable until o_valid&&o_ready.
REQ-022 On an OUT handshake with k<2^NQ-1, the block SHALL set k=k+1, reload acc per REQ-018 and return to MULT.
- With k=2^NQ-1 it SHALL return to IDLE and clear q_cnt.
REQ-023 o_valid SHALL be low in IDLE, LOAD and MULT.
- o_re, o_im and o_idx read 0 outside OUT.
REQ-024 ovr_flag SHALL be set by any multiplier ovr during MULT and SHALL hold until the next first-qubit accept or reset.
REQ-025 abort SHALL force IDLE next cycle from any state, clear q_cnt and k, and leave ovr_flag unchanged.
- abort has priority over a simultaneous q or o handshake, and that handshake is discarded.
REQ-026 Total throughput SHALL be 2^NQ amplitudes, each costing NQ-1 MULT cycles plus at least one OUT cycle.

Reset
REQ-027 While rst_n is low, the state SHALL be IDLE, and q_cnt, k, step, acc, qubit slots, ovr_flag, o_valid, o_re, o_im, o_idx, o_last and busy SHALL be 0.
- q_ready is 1 in IDLE.
REQ-028 Reset asserted mid-operation SHALL abandon the operation with no further output handshakes.

Configuration
REQ-029 With KRON_OVR_EN defined, ovr_flag SHALL behave per REQ-024.
- Without it, ovr_flag is constant 0 and no sticky register exists.
- The port is present in both cases.

Structure
REQ-030 Package qsim_pkg SHALL hold:
- cplx_t, a struct of re and im, each N bits;
- the state enum type;
- Q_ONE, the value 1.0 in the complex_mult fixed-point format.
REQ-031 The block SHALL instantiate exactly one complex_mult #(N) as its sole sub-module.

Verification
REQ-032 NQ=4, all qubits (Q_ONE,0,0,0) -> idx 0 = (Q_ONE,0), idx 1..15 = (0,0), o_last at idx 15, ovr_flag=0.
REQ-033 NQ=4, all qubits (Q_ONE/2,0,Q_ONE/2,0) -> all 16 amplitudes = (Q_ONE/16,0) in index order.
REQ-034 NQ=2, q0=(Q_ONE,0,0,0) and q1=(0,0,0,Q_ONE) -> idx 1 = (0,Q_ONE), others 0.
- o_valid rises exactly 1 cycle after entering MULT.
REQ-035 o_ready held low 5 cycles at idx 3 -> o_re, o_im and o_idx stable throughout, no skipped index.
REQ-036 abort during MULT at k=6, then rst_n pulse during LOAD -> IDLE, no o_valid, all outputs 0.
- A following full load produces idx 0 first.
